// File: rtl/shared_ocm_pkg.sv
// Shared definitions for the shared on-chip memory arbiter.
package shared_ocm_pkg;

  localparam int OCM_ADDR_W = 8;
  localparam int OCM_DATA_W = 32;
  localparam int OCM_BE_W   = 4;

  // Storage width of the lock idle counter; the top saturates it at
  // clog2(LOCK_TIMEOUT)+1 bits, so LOCK_TIMEOUT must stay below 2**15.
  localparam int LOCK_CNT_W = 16;

  // Ceiling log2 for parameter arithmetic.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Lock holder state: active flag, owning requester, idle cycles seen.
  typedef struct packed {
    logic                  lock_active;
    logic [1:0]            lock_owner;
    logic [LOCK_CNT_W-1:0] idle_cnt;
  } lock_state_t;

endpackage

// File: rtl/shared_ocm_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester after ptr.
module rr_arbiter
  import shared_ocm_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant
);

  logic found;

  // Scan ptr+1, ptr+2, ... cyclically; the first masked-in request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && mask[i] && (i == ((int'(ptr) + k) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_ocm_arbiter.sv
// Round-robin arbiter with lock/watchdog in front of one shared OCM port.
// Handshake: a requester's command is accepted in any cycle where it
// asserts read or write and sees req_waitrequest low; read data returns
// exactly one cycle later on the shared bus, flagged by its one-hot
// req_readdatavalid bit.
module shared_ocm_arbiter
  import shared_ocm_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = OCM_ADDR_W,
  parameter int DATA_W       = OCM_DATA_W,
  parameter int BE_W         = OCM_BE_W,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic [BE_W-1:0]           mem_byteenable,
  input  logic [DATA_W-1:0]         mem_readdata,
  output logic [1:0]                lock_owner,
  output logic                      lock_active,
  output logic                      lock_timeout_err
);

  localparam int CNT_W = clog2(LOCK_TIMEOUT) + 1;
  localparam logic [LOCK_CNT_W-1:0] CNT_SAT  = LOCK_CNT_W'((1 << CNT_W) - 1);
  localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOCK_CNT_W-1:0] CNT_ONE  = LOCK_CNT_W'(1);

  logic [NUM_REQ-1:0] req_v, req_elig, elig_mask, grant;
  logic               gnt_any;
  logic [1:0]         gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [BE_W-1:0]    sel_be;
  logic               sel_read, sel_write, sel_lock;
  logic               owner_req, owner_lock;

  logic [1:0]         ptr_q, ptr_d;
  lock_state_t        lock_q, lock_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;

  // Requests are ignored while reset is held so the port stays idle.
  assign req_v    = req_read | req_write;
  assign req_elig = req_v & {NUM_REQ{~reset}};

  // While locked only the owner is eligible; the pre-edge lock state rules.
  always_comb begin
    elig_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_mask[i] = !lock_q.lock_active || (int'(lock_q.lock_owner) == i);
    end
  end

  rr_arbiter #(.N(NUM_REQ), .PTR_W(2)) u_rr (
    .req   (req_elig),
    .ptr   (ptr_q),
    .mask  (elig_mask),
    .grant (grant)
  );

  assign gnt_any = |grant;

  // Pick the granted requester's command and the lock owner's status.
  always_comb begin
    gnt_idx    = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_be     = '0;
    sel_read   = 1'b0;
    sel_write  = 1'b0;
    sel_lock   = 1'b0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx   = 2'(i);
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_wdata = req_writedata[i*DATA_W +: DATA_W];
        sel_be    = req_byteenable[i*BE_W +: BE_W];
        sel_read  = req_read[i];
        sel_write = req_write[i];
        sel_lock  = req_lock[i];
      end
      if (int'(lock_q.lock_owner) == i) begin
        owner_req  = req_v[i];
        owner_lock = req_lock[i];
      end
    end
  end

  // Memory command: live from the winner, otherwise hold last address/data.
  always_comb begin
    mem_chipselect = gnt_any;
    mem_write      = gnt_any & sel_write;
    mem_address    = gnt_any ? sel_addr : addr_q;
    mem_writedata  = gnt_any ? sel_wdata : wdata_q;
    mem_byteenable = gnt_any ? (sel_write ? sel_be : {BE_W{1'b1}}) : be_q;
    addr_d         = mem_address;
    wdata_d        = mem_writedata;
    be_d           = mem_byteenable;
    ptr_d          = gnt_any ? gnt_idx : ptr_q;
    // A read+write pair is a write, so it never produces a return.
    rd_pend_d      = (gnt_any && sel_read && !sel_write) ? grant : '0;
  end

  // Lock acquisition, release and idle watchdog.
  always_comb begin
    lock_d = lock_q;
    err_d  = 1'b0;
    if (lock_q.lock_active) begin
      if (gnt_any) begin
        lock_d.idle_cnt = '0;
        if (!sel_lock) lock_d.lock_active = 1'b0;
      end else if (!owner_lock) begin
        lock_d.lock_active = 1'b0;
        lock_d.idle_cnt    = '0;
      end else if (!owner_req) begin
        if (lock_q.idle_cnt == CNT_LAST) begin
          lock_d.lock_active = 1'b0;
          lock_d.idle_cnt    = '0;
          err_d              = 1'b1;
        end else if (lock_q.idle_cnt != CNT_SAT) begin
          lock_d.idle_cnt = lock_q.idle_cnt + CNT_ONE;
        end
      end
    end else if (gnt_any && sel_lock) begin
      lock_d.lock_active = 1'b1;
      lock_d.lock_owner  = gnt_idx;
      lock_d.idle_cnt    = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= 2'(NUM_REQ - 1);
      lock_q    <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  assign req_waitrequest   = ~grant;
  assign req_readdata      = mem_readdata;
  assign req_readdatavalid = rd_pend_q & {NUM_REQ{~reset}};
  assign lock_active       = lock_q.lock_active;
  assign lock_owner        = lock_q.lock_owner;
  assign lock_timeout_err  = err_q;

endmodule

// File: tb/tb_shared_ocm_arbiter.sv
// Directed bench for shared_ocm_arbiter with a behavioural OCM model.
module tb_shared_ocm_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] req_address;
  logic [1:0]  req_read, req_write, req_lock;
  logic [63:0] req_writedata;
  logic [7:0]  req_byteenable;
  logic [1:0]  req_waitrequest, req_readdatavalid;
  logic [31:0] req_readdata;
  logic [7:0]  mem_address;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;
  logic [1:0]  lock_owner;
  logic        lock_active, lock_timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  shared_ocm_arbiter #(
    .NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .BE_W(4), .LOCK_TIMEOUT(8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_lock          (req_lock),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_readdata      (mem_readdata),
    .lock_owner        (lock_owner),
    .lock_active       (lock_active),
    .lock_timeout_err  (lock_timeout_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OCM model: unwritten word a reads as {4{a}}; registered address.
  logic [31:0]  mem [256];
  logic [255:0] written = '0;
  logic [7:0]   mem_addr_r = '0;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return written[a] ? mem[a] : {4{a}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_addr_r <= mem_address;
      if (mem_write) begin
        mem[mem_address]     <= merge(mem_word(mem_address), mem_writedata, mem_byteenable);
        written[mem_address] <= 1'b1;
      end
    end
  end

  assign mem_readdata = mem_word(mem_addr_r);

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be, input logic lk);
    req_read[i]               = rd;
    req_write[i]              = wr;
    req_address[i*8 +: 8]     = a;
    req_writedata[i*32 +: 32] = d;
    req_byteenable[i*4 +: 4]  = be;
    req_lock[i]               = lk;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle(0);
    idle(1);
    repeat (2) tick();

    // Reset values
    check("rst_waitreq", 32'(req_waitrequest), 32'h3);
    check("rst_cs", 32'(mem_chipselect), 32'h0);
    check("rst_wr", 32'(mem_write), 32'h0);
    check("rst_rdv", 32'(req_readdatavalid), 32'h0);
    check("rst_lock", 32'(lock_active), 32'h0);
    check("rst_owner", 32'(lock_owner), 32'h0);
    check("rst_err", 32'(lock_timeout_err), 32'h0);

    reset = 1'b0;
    tick();
    tick();
    check("idle_waitreq", 32'(req_waitrequest), 32'h3);
    check("idle_cs", 32'(mem_chipselect), 32'h0);
    check("idle_rdv", 32'(req_readdatavalid), 32'h0);

    // Both requesters read continuously: grants alternate from requester 0
    drive(0, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0, 1'b0);
    #1;
    check("rr0_waitreq", 32'(req_waitrequest), 32'h2);
    check("rr0_addr", 32'(mem_address), 32'h01);
    check("rr0_rdv", 32'(req_readdatavalid), 32'h0);
    tick();
    check("rr1_waitreq", 32'(req_waitrequest), 32'h1);
    check("rr1_addr", 32'(mem_address), 32'h02);
    check("rr1_rdv", 32'(req_readdatavalid), 32'h1);
    check("rr1_data", req_readdata, 32'h01010101);
    tick();
    check("rr2_waitreq", 32'(req_waitrequest), 32'h2);
    check("rr2_rdv", 32'(req_readdatavalid), 32'h2);
    check("rr2_data", req_readdata, 32'h02020202);
    tick();
    check("rr3_waitreq", 32'(req_waitrequest), 32'h1);
    check("rr3_rdv", 32'(req_readdatavalid), 32'h1);
    check("rr3_data", req_readdata, 32'h01010101);
    tick();
    idle(0);
    idle(1);
    #1;
    check("rr4_rdv", 32'(req_readdatavalid), 32'h2);
    check("rr4_data", req_readdata, 32'h02020202);
    check("rr4_cs", 32'(mem_chipselect), 32'h0);
    tick();

    // Single write then read by requester 0
    drive(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    #1;
    check("wr_waitreq", 32'(req_waitrequest), 32'h2);
    check("wr_cs", 32'(mem_chipselect), 32'h1);
    check("wr_we", 32'(mem_write), 32'h1);
    check("wr_addr", 32'(mem_address), 32'h10);
    check("wr_data", mem_writedata, 32'hDEADBEEF);
    check("wr_be", 32'(mem_byteenable), 32'hF);
    tick();
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    #1;
    check("wr_rdv_none", 32'(req_readdatavalid), 32'h0);
    check("rd_waitreq", 32'(req_waitrequest), 32'h2);
    check("rd_we", 32'(mem_write), 32'h0);
    check("rd_be", 32'(mem_byteenable), 32'hF);
    tick();
    idle(0);
    #1;
    check("rd_rdv", 32'(req_readdatavalid), 32'h1);
    check("rd_data", req_readdata, 32'hDEADBEEF);
    check("hold_cs", 32'(mem_chipselect), 32'h0);
    check("hold_addr", 32'(mem_address), 32'h10);
    tick();
    check("rd_rdv_once", 32'(req_readdatavalid), 32'h0);

    // Locked read-modify-write by requester 1 while requester 0 waits
    drive(1, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0, 1'b1);
    drive(0, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0, 1'b0);
    #1;
    check("rmw_a_waitreq", 32'(req_waitrequest), 32'h1);
    check("rmw_a_addr", 32'(mem_address), 32'h20);
    check("rmw_a_lock", 32'(lock_active), 32'h0);
    tick();
    drive(1, 1'b0, 1'b0, 8'h20, 32'h0, 4'h0, 1'b1);
    #1;
    check("rmw_b_waitreq", 32'(req_waitrequest), 32'h3);
    check("rmw_b_cs", 32'(mem_chipselect), 32'h0);
    check("rmw_b_rdv", 32'(req_readdatavalid), 32'h2);
    check("rmw_b_data", req_readdata, 32'h20202020);
    check("rmw_b_lock", 32'(lock_active), 32'h1);
    check("rmw_b_owner", 32'(lock_owner), 32'h1);
    tick();
    drive(1, 1'b0, 1'b1, 8'h20, 32'h20202021, 4'hF, 1'b0);
    #1;
    check("rmw_c_waitreq", 32'(req_waitrequest), 32'h1);
    check("rmw_c_we", 32'(mem_write), 32'h1);
    check("rmw_c_data", mem_writedata, 32'h20202021);
    tick();
    idle(1);
    #1;
    check("rmw_d_lock", 32'(lock_active), 32'h0);
    check("rmw_d_waitreq", 32'(req_waitrequest), 32'h2);
    check("rmw_d_rdv", 32'(req_readdatavalid), 32'h0);
    tick();
    idle(0);
    #1;
    check("rmw_e_rdv", 32'(req_readdatavalid), 32'h1);
    check("rmw_e_data", req_readdata, 32'h01010101);
    check("rmw_mem", mem_word(8'h20), 32'h20202021);
    tick();

    // Lock timeout: requester 0 locks then idles, requester 1 waits
    drive(0, 1'b1, 1'b0, 8'h02, 32'h0, 4'h0, 1'b1);
    #1;
    check("to_lock_waitreq", 32'(req_waitrequest), 32'h2);
    tick();
    drive(0, 1'b0, 1'b0, 8'h02, 32'h0, 4'h0, 1'b1);
    drive(1, 1'b1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
    #1;
    check("to_rdv", 32'(req_readdatavalid), 32'h1);
    check("to_data", req_readdata, 32'h02020202);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("to_idle%0d_waitreq", c), 32'(req_waitrequest), 32'h3);
      check($sformatf("to_idle%0d_lock", c), 32'(lock_active), 32'h1);
      check($sformatf("to_idle%0d_err", c), 32'(lock_timeout_err), 32'h0);
      tick();
    end
    check("to_err_pulse", 32'(lock_timeout_err), 32'h1);
    check("to_released", 32'(lock_active), 32'h0);
    check("to_grant1", 32'(req_waitrequest), 32'h1);
    check("to_addr", 32'(mem_address), 32'h03);
    tick();
    idle(0);
    idle(1);
    #1;
    check("to_err_once", 32'(lock_timeout_err), 32'h0);
    check("to_rdv1", 32'(req_readdatavalid), 32'h2);
    check("to_data1", req_readdata, 32'h03030303);
    tick();

    // Simultaneous read+write is a write with no read return
    drive(0, 1'b1, 1'b1, 8'h30, 32'hCAFEF00D, 4'h3, 1'b0);
    #1;
    check("rw_we", 32'(mem_write), 32'h1);
    check("rw_be", 32'(mem_byteenable), 32'h3);
    tick();
    idle(0);
    #1;
    check("rw_rdv", 32'(req_readdatavalid), 32'h0);
    check("rw_mem", mem_word(8'h30), 32'h3030F00D);
    tick();

    // Reset in the cycle after a locked read accept
    drive(0, 1'b1, 1'b0, 8'h01, 32'h0, 4'h0, 1'b1);
    #1;
    check("mr_waitreq", 32'(req_waitrequest), 32'h2);
    tick();
    idle(0);
    reset = 1'b1;
    #1;
    check("mr_rdv_in_reset", 32'(req_readdatavalid), 32'h0);
    tick();
    check("mr_lock", 32'(lock_active), 32'h0);
    check("mr_rdv", 32'(req_readdatavalid), 32'h0);
    check("mr_err", 32'(lock_timeout_err), 32'h0);
    check("mr_waitreq_rst", 32'(req_waitrequest), 32'h3);
    reset = 1'b0;
    tick();
    check("mr_rdv_after", 32'(req_readdatavalid), 32'h0);
    check("mr_lock_after", 32'(lock_active), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_ocm_arbiter.md
Name: shared_ocm_arbiter

Overview:
- Shares one Avalon port of the 256x32 dual-port shared on-chip memory between NUM_REQ local masters, for example a worker CPU and a DMA engine.
- Arbitration is round-robin and grants one transfer per cycle.
- Adds a lock mechanism for atomic read-modify-write sequences, with an idle-timeout watchdog.
- Sits between the masters and the memory slave port. It is pure control; the memory itself is unchanged.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 8, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- LOCK_TIMEOUT, 64, idle cycles a lock may be held before forced release (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- req_address  in  NUM_REQ*ADDR_W  per-requester word address; slice i is requester i
- req_read  in  NUM_REQ  read request
- req_write  in  NUM_REQ  write request
- req_writedata  in  NUM_REQ*DATA_W  write data
- req_byteenable  in  NUM_REQ*BE_W  byte enables
- req_lock  in  NUM_REQ  hold grant after this transfer
- req_waitrequest  out  NUM_REQ  high = command not accepted this cycle
- req_readdata  out  DATA_W  read data, shared bus, qualified by req_readdatavalid
- req_readdatavalid  out  NUM_REQ  one-hot read return strobe
- mem_address  out  ADDR_W  to memory port
- mem_chipselect  out  1
- mem_write  out  1
- mem_writedata  out  DATA_W
- mem_byteenable  out  BE_W
- mem_readdata  in  DATA_W  memory q (address registered, output unregistered)
- lock_owner  out  2  index of current lock holder
- lock_active  out  1  lock held
- lock_timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Clocking and reset: one clock domain; synchronous, active-high reset.
- Reset values:
  - req_waitrequest all 1.
  - req_readdatavalid 0.
  - mem_chipselect 0, mem_write 0.
  - lock_active 0, lock_owner 0, lock_timeout_err 0.
  - RR pointer = NUM_REQ-1, so requester 0 has highest priority first.
  - Idle counter 0.
  - Any in-flight readdatavalid is dropped.
- Request: req_i = req_read[i] | req_write[i].
- Grant:
  - Combinational, one-hot. It is the first requesting index after the RR pointer, scanning cyclically.
  - If lock_active, only lock_owner may be granted; others see waitrequest=1.
  - req_waitrequest[i] = ~grant[i], combinational from inputs. An idle requester sees 1.
- Accept cycle (grant[g]=1):
  - mem_* driven combinationally from slice g; mem_chipselect=1.
  - mem_write = req_write[g].
  - mem_byteenable = slice g for writes, all-ones for reads.
  - RR pointer <= g on the clock edge.
- No grant: mem_chipselect=0, mem_write=0; address and data hold their last values.
- Read latency is exactly 1:
  - An accepted read sets rd_pend_onehot <= grant.
  - Next cycle req_readdatavalid = rd_pend_onehot and req_readdata = mem_readdata (passthrough).
  - Back-to-back reads from any mix of requesters give one return per cycle, in order.
- Writes complete in the accept cycle. No readdatavalid is produced for a write.
- req_read and req_write both high: treated as a write; no read return.
- Lock:
  - An accepted transfer with req_lock=1 sets lock_active=1 and lock_owner=g.
  - An accepted transfer by the owner with req_lock=0 clears lock_active after that transfer.
  - Owner dropping req_lock while not requesting also clears it next edge.
- Idle counter:
  - Counts cycles while lock_active and the owner has no request.
  - Reset to 0 on any owner accept.
  - Saturating width is clog2(LOCK_TIMEOUT)+1.
  - On count == LOCK_TIMEOUT-1: lock_active <= 0, lock_timeout_err pulses 1 cycle, counter <= 0.
  - Normal arbitration resumes next cycle.
- Lock release and a new grant in the same cycle: the new grant follows the pre-edge lock state. The release takes effect next cycle.
- Reset mid-lock or mid-read: lock cleared, pending read discarded, no error pulse.

Decomposition:
- Package shared_ocm_pkg holds:
  - constants OCM_ADDR_W=8, OCM_DATA_W=32, OCM_BE_W=4;
  - localparam function for clog2;
  - typedef of the lock state (lock_active, lock_owner, idle_cnt).
- One sub-module, rr_arbiter. It is a parameterized combinational round-robin picker: inputs request vector, pointer and mask; output one-hot grant. It is instantiated once.
- Lock FSM, counters and muxing stay in the top module.

Test Plan:
- Reset then idle:
  - All req_waitrequest=1, mem_chipselect=0, readdatavalid=0.
  - After reset release with no requests, outputs unchanged.
- Single write then read by req0:
  - Write addr 0x10, data 0xDEADBEEF, be 0xF: accepted cycle 0, mem_write=1.
  - Read 0x10: readdatavalid[0]=1 exactly one cycle after accept, readdata=0xDEADBEEF.
- Both requesters read continuously, addresses 0x01 and 0x02:
  - Grants alternate 0,1,0,1 starting with 0.
  - Each readdatavalid one-hot follows its accept by 1 cycle, with data matching the preloaded words.
- Locked RMW:
  - req1 reads 0x20 with lock=1; req0 requests continuously.
  - req1 then writes 0x20 with lock=0 two cycles later.
  - req0 is held off until after the write, then granted the next cycle.
  - Final mem[0x20] equals req1's data.
- Lock timeout, LOCK_TIMEOUT=8:
  - req0 locks then goes idle; req1 requests.
  - After 8 idle cycles lock_timeout_err pulses once and lock_active=0.
  - req1 is granted the following cycle.
- Simultaneous read+write from req0, and reset mid-read:
  - req0 asserts read and write together: write performed, no readdatavalid.
  - Reset asserted in the cycle after a read accept: readdatavalid stays 0 and lock_active=0.
